// File: rtl/ped_request_ctrl_pkg.sv
// Shared definitions for the pedestrian request controller and the pedestrian light block.
package ped_request_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_WALK    = 2'd2,
    ST_HOLDOFF = 2'd3
  } ped_state_e;

  localparam int unsigned TIME_W_DEFAULT    = 7;
  // Walk duration the pedestrian light block returns unless reconfigured.
  localparam int unsigned DEFAULT_WALK_TIME = 25;

endpackage : ped_request_ctrl_pkg

// File: rtl/ped_request_ctrl_button_debounce.sv
// Two-flop synchroniser, saturating debounce counter and rising-edge press detector.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press_pulse,
  output logic level
);

  localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          s1_q;
  logic          s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          deb_q;
  logic          deb_d;
  logic          deb_prev_q;

  // deb follows the counter's next value so it rises on the same edge cnt saturates.
  always_comb begin
    cnt_d = '0;
    if (s2_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    deb_d = s2_q && (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      s1_q       <= raw;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
    end
  end

  assign press_pulse = deb_q && !deb_prev_q;
  assign level       = deb_q;

endmodule : button_debounce

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: debounced button latch, walk timer and post-walk hold-off.
module ped_request_ctrl
  import ped_request_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLDOFF_TICKS   = 5,
  parameter int unsigned TIME_W          = TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              sec_tick,
  input  logic              phase_done,
  input  logic [TIME_W-1:0] load_time,
  output logic              ped_signal,
  output logic              ped_pending,
  output logic [TIME_W-1:0] time_left,
  output logic              ped_done
);

  localparam int unsigned   HW        = $clog2(HOLDOFF_TICKS + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_TICKS);

  ped_state_e        state_q;
  ped_state_e        state_d;
  logic [TIME_W-1:0] time_left_q;
  logic [TIME_W-1:0] time_left_d;
  logic [HW-1:0]     hold_q;
  logic [HW-1:0]     hold_d;
  logic              queued_q;
  logic              queued_d;
  logic              ped_done_q;
  logic              ped_done_d;

  logic btn_press;
  logic btn_level;
  logic press_evt;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .raw        (button),
    .press_pulse(btn_press),
    .level      (btn_level)
  );

  assign press_evt = btn_press && btn_level;

  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    hold_d      = hold_q;
    queued_d    = queued_q;
    ped_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (press_evt) begin
          state_d = ST_PENDING;
        end
      end

      ST_PENDING: begin
        if (phase_done) begin
          if (load_time == '0) begin
            state_d    = ST_HOLDOFF;
            hold_d     = HOLD_INIT;
            ped_done_d = 1'b1;
          end else begin
            state_d     = ST_WALK;
            time_left_d = load_time;
          end
        end
      end

      ST_WALK: begin
        if (press_evt) begin
          queued_d = 1'b1;
        end
        if (sec_tick) begin
          if (time_left_q <= TIME_W'(1)) begin
            time_left_d = '0;
            state_d     = ST_HOLDOFF;
            hold_d      = HOLD_INIT;
            ped_done_d  = 1'b1;
          end else begin
            time_left_d = time_left_q - TIME_W'(1);
          end
        end
      end

      ST_HOLDOFF: begin
        if (press_evt) begin
          queued_d = 1'b1;
        end
        // A press landing on the exit tick still counts as queued.
        if (sec_tick) begin
          if (hold_q <= HW'(1)) begin
            hold_d   = '0;
            state_d  = (queued_q || press_evt) ? ST_PENDING : ST_IDLE;
            queued_d = 1'b0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      time_left_q <= '0;
      hold_q      <= '0;
      queued_q    <= 1'b0;
      ped_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      hold_q      <= hold_d;
      queued_q    <= queued_d;
      ped_done_q  <= ped_done_d;
    end
  end

  assign ped_signal  = (state_q == ST_WALK);
  assign ped_pending = (state_q == ST_PENDING);
  assign time_left   = time_left_q;
  assign ped_done    = ped_done_q;

endmodule : ped_request_ctrl

// File: tb/tb_ped_request_ctrl.sv
// Self-checking bench for ped_request_ctrl using an expected-value queue.
module tb_ped_request_ctrl;
  import ped_request_ctrl_pkg::*;

  typedef logic [7:0] v8_t;

  logic       clk;
  logic       rst;
  logic       button;
  logic       sec_tick;
  logic       phase_done;
  logic [6:0] load_time;
  logic       ped_signal;
  logic       ped_pending;
  logic [6:0] time_left;
  logic       ped_done;

  int  checks;
  int  failures;
  int  done_cnt;
  v8_t exp_q[$];
  v8_t e;

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_TICKS  (5),
    .TIME_W         (7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .sec_tick   (sec_tick),
    .phase_done (phase_done),
    .load_time  (load_time),
    .ped_signal (ped_signal),
    .ped_pending(ped_pending),
    .time_left  (time_left),
    .ped_done   (ped_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk or posedge rst) begin
    if (rst) done_cnt <= 0;
    else if (ped_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      sec_tick = 1'b1;
      cyc(1);
      sec_tick = 1'b0;
      cyc(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; button = 1'b0; sec_tick = 1'b0; phase_done = 1'b0; load_time = '0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  // Raise the button and count edges until ped_pending, bounded at 20.
  task automatic press_wait(output int n);
    button = 1'b1;
    n = 0;
    while (!ped_pending && n < 20) begin
      cyc(1);
      n++;
    end
    button = 1'b0;
  endtask

  task automatic start_walk(input logic [6:0] lt);
    phase_done = 1'b1;
    load_time  = lt;
    cyc(1);
    phase_done = 1'b0;
    load_time  = 7'd99;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 1'b0; sec_tick = 1'b0; phase_done = 1'b0; load_time = '0;
    cyc(2);
    exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL reset_signal got=%0d exp=%0d", ped_signal, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL reset_pending got=%0d exp=%0d", ped_pending, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(time_left) !== e) begin failures++; $display("FAIL reset_time got=%0d exp=%0d", time_left, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_done) !== e) begin failures++; $display("FAIL reset_done got=%0d exp=%0d", ped_done, e); end
    rst = 1'b0;
    cyc(3);
    exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL post_reset_pending got=%0d exp=%0d", ped_pending, e); end
  endtask

  task automatic test_debounce();
    do_reset();
    button = 1'b1; cyc(3); button = 1'b0;
    exp_q.push_back(8'd0);
    cyc(10);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL deb_glitch got=%0d exp=%0d", ped_pending, e); end

    // Held button: pending appears after edge 7 and only one event is produced.
    button = 1'b1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    cyc(6);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL deb_edge6 got=%0d exp=%0d", ped_pending, e); end
    cyc(1);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL deb_edge7 got=%0d exp=%0d", ped_pending, e); end
    start_walk(7'd2);
    exp_q.push_back(8'd1);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL deb_walk got=%0d exp=%0d", ped_signal, e); end
    tick_n(2 + 5);
    exp_q.push_back(8'd0);
    cyc(10);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL deb_single_event got=%0d exp=%0d", ped_pending, e); end
    button = 1'b0;
  endtask

  task automatic test_full_cycle();
    int n;
    int d0;
    do_reset();
    press_wait(n);
    exp_q.push_back(8'd7);
    e = exp_q.pop_front(); checks++;
    if (8'(n) !== e) begin failures++; $display("FAIL full_press_latency got=%0d exp=%0d", n, e); end
    exp_q.push_back(8'd1); exp_q.push_back(8'(DEFAULT_WALK_TIME));
    start_walk(7'(DEFAULT_WALK_TIME));
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL full_signal got=%0d exp=%0d", ped_signal, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(time_left) !== e) begin failures++; $display("FAIL full_load got=%0d exp=%0d", time_left, e); end
    d0 = done_cnt;
    for (int i = 24; i >= 0; i--) begin
      exp_q.push_back(8'(i));
      cyc(1);
      sec_tick = 1'b1;
      cyc(1);
      sec_tick = 1'b0;
      e = exp_q.pop_front(); checks++;
      if (8'(time_left) !== e) begin failures++; $display("FAIL full_countdown got=%0d exp=%0d", time_left, e); end
    end
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL full_end_signal got=%0d exp=%0d", ped_signal, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_done) !== e) begin failures++; $display("FAIL full_done_pulse got=%0d exp=%0d", ped_done, e); end
    cyc(1);
    exp_q.push_back(8'd0); exp_q.push_back(8'(d0 + 1));
    e = exp_q.pop_front(); checks++;
    if (8'(ped_done) !== e) begin failures++; $display("FAIL full_done_width got=%0d exp=%0d", ped_done, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(done_cnt) !== e) begin failures++; $display("FAIL full_done_count got=%0d exp=%0d", done_cnt, e); end
    tick_n(5);
    press_wait(n);
    exp_q.push_back(8'd7);
    e = exp_q.pop_front(); checks++;
    if (8'(n) !== e) begin failures++; $display("FAIL full_back_to_idle got=%0d exp=%0d", n, e); end
  endtask

  task automatic test_queued();
    int n;
    do_reset();
    press_wait(n);
    start_walk(7'd3);
    button = 1'b1; cyc(8); button = 1'b0;
    tick_n(3);
    exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL queued_walk_end got=%0d exp=%0d", ped_signal, e); end
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    tick_n(4);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL queued_holdoff4 got=%0d exp=%0d", ped_pending, e); end
    tick_n(1);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL queued_pending got=%0d exp=%0d", ped_pending, e); end
  endtask

  task automatic test_zero_load();
    int n;
    do_reset();
    press_wait(n);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    start_walk(7'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL zero_signal got=%0d exp=%0d", ped_signal, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_done) !== e) begin failures++; $display("FAIL zero_done got=%0d exp=%0d", ped_done, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL zero_pending got=%0d exp=%0d", ped_pending, e); end
    button = 1'b1; cyc(8); button = 1'b0; cyc(3);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL zero_in_holdoff got=%0d exp=%0d", ped_pending, e); end
    tick_n(5);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL zero_holdoff_exit got=%0d exp=%0d", ped_pending, e); end
  endtask

  task automatic test_reset_mid_walk();
    int n;
    int d0;
    do_reset();
    press_wait(n);
    start_walk(7'd12);
    tick_n(2);
    exp_q.push_back(8'd10);
    e = exp_q.pop_front(); checks++;
    if (8'(time_left) !== e) begin failures++; $display("FAIL rstwalk_time10 got=%0d exp=%0d", time_left, e); end
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(8'd0); exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL rstwalk_signal got=%0d exp=%0d", ped_signal, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(time_left) !== e) begin failures++; $display("FAIL rstwalk_time got=%0d exp=%0d", time_left, e); end
    cyc(2);
    rst = 1'b0;
    cyc(3);
    exp_q.push_back(8'(d0 > 0 ? 0 : 0)); exp_q.push_back(8'd7);
    e = exp_q.pop_front(); checks++;
    if (8'(done_cnt) !== e) begin failures++; $display("FAIL rstwalk_no_done got=%0d exp=%0d", done_cnt, e); end
    press_wait(n);
    e = exp_q.pop_front(); checks++;
    if (8'(n) !== e) begin failures++; $display("FAIL rstwalk_idle got=%0d exp=%0d", n, e); end
  endtask

  task automatic test_simul_idle();
    do_reset();
    button = 1'b1;
    cyc(6);
    phase_done = 1'b1;
    load_time  = 7'd5;
    cyc(1);
    phase_done = 1'b0;
    button = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL simidle_pending got=%0d exp=%0d", ped_pending, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL simidle_signal got=%0d exp=%0d", ped_signal, e); end
    cyc(4);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd5);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL simidle_wait got=%0d exp=%0d", ped_signal, e); end
    start_walk(7'd5);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL simidle_walk got=%0d exp=%0d", ped_signal, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(time_left) !== e) begin failures++; $display("FAIL simidle_time got=%0d exp=%0d", time_left, e); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    press_wait(n);
    start_walk(7'd2);
    tick_n(1);
    exp_q.push_back(8'd1);
    e = exp_q.pop_front(); checks++;
    if (8'(time_left) !== e) begin failures++; $display("FAIL b2b_time1 got=%0d exp=%0d", time_left, e); end
    // Press event and the final tick land on the same edge.
    button = 1'b1;
    cyc(6);
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
    button = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_done) !== e) begin failures++; $display("FAIL b2b_done got=%0d exp=%0d", ped_done, e); end
    e = exp_q.pop_front(); checks++;
    if (8'(ped_signal) !== e) begin failures++; $display("FAIL b2b_signal got=%0d exp=%0d", ped_signal, e); end
    cyc(1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    tick_n(4);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL b2b_holdoff4 got=%0d exp=%0d", ped_pending, e); end
    tick_n(1);
    e = exp_q.pop_front(); checks++;
    if (8'(ped_pending) !== e) begin failures++; $display("FAIL b2b_queued got=%0d exp=%0d", ped_pending, e); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_debounce();
    test_full_cycle();
    test_queued();
    test_zero_load();
    test_reset_mid_walk();
    test_simul_idle();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ped_request_ctrl

// File: doc/ped_request_ctrl.md
Name: ped_request_ctrl

Overview:
- Upstream producer of the pedestrian-phase request for the traffic-light controller.
- Takes the raw crosswalk push-button and synchronises and debounces it. Latches the request until the main FSM reaches a safe phase boundary, then drives `ped_signal` for the loaded walk time, counted in second ticks.
- Applies a minimum hold-off before a new walk phase may start.
- `ped_signal` feeds the pedestrian light/lane block, and `load_time` is that block's returned walk duration.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high clock samples required to accept a press (>=1).
- HOLDOFF_TICKS, 5, `sec_tick` pulses of mandatory gap after a walk phase ends (>=1).
- TIME_W, 7, width of `load_time` and `time_left`.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- button  input  1  raw crosswalk button, asynchronous to `clk`, active-high.
- sec_tick  input  1  one-cycle pulse per second from the timebase.
- phase_done  input  1  main FSM at a safe boundary; a pending request may start now.
- load_time  input  TIME_W  walk duration in seconds, sampled on entry to WALK.
- ped_signal  output  1  pedestrian phase active; drives the pedestrian light block.
- ped_pending  output  1  request latched, waiting for `phase_done`.
- time_left  output  TIME_W  remaining walk seconds; 0 outside WALK.
- ped_done  output  1  one-cycle pulse when a walk phase ends.

Behaviour:
- Reset: `rst` high asynchronously clears everything.
  - All outputs go to 0, state goes to IDLE.
  - Synchroniser flops, debounce counter, debounced level, queued flag and hold-off counter all clear.
  - Reset asserted mid-WALK drops `ped_signal` immediately and does not pulse `ped_done`.
- Synchroniser: two flops, `s1` then `s2`.
- Debounce:
  - `cnt` increments while `s2`=1, saturating at DEBOUNCE_CYCLES, and clears to 0 when `s2`=0.
  - `deb` sets at the edge where `cnt` reaches DEBOUNCE_CYCLES and clears when `s2`=0.
  - Press event = `deb` & ~`deb_q` (rising edge only); holding the button yields one event.
- Latency: `button` first sampled high at edge 1 and held → `ped_pending`=1 after edge DEBOUNCE_CYCLES+3.
- States: IDLE, PENDING, WALK, HOLDOFF. Outputs are registered/Moore.
  - IDLE: on press event → PENDING.
  - PENDING: `ped_pending`=1.
    - If `phase_done`=1 → WALK, loading `time_left` ← `load_time`.
    - If `load_time`==0: go directly to HOLDOFF and pulse `ped_done`; `ped_signal` never asserts.
  - WALK: `ped_signal`=1.
    - Each `sec_tick` decrements `time_left`.
    - The tick taking `time_left` 1→0 moves to HOLDOFF with `ped_done`=1 for that next cycle.
    - Changes on `load_time` during WALK are ignored.
  - HOLDOFF: counter loads HOLDOFF_TICKS on entry and decrements per `sec_tick`. At 0 → PENDING if `queued`=1, else IDLE. `queued` clears on exit.
- Press events in WALK or HOLDOFF set `queued`; extra presses have no further effect.
- Presses in PENDING are absorbed with no effect.
- `phase_done` is ignored outside PENDING.
- `sec_tick` is ignored in IDLE/PENDING.
- Simultaneous press event and `phase_done` in IDLE → PENDING only; WALK requires a later `phase_done`.
- Simultaneous final `sec_tick` and press event in WALK → HOLDOFF with `queued`=1.
- A glitch on `button` shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Arithmetic: `time_left` and hold-off counter are unsigned, never decrement below 0, no wrap.

Decomposition:
- Shared package/header:
  - state encoding constants ST_IDLE=2'd0, ST_PENDING=2'd1, ST_WALK=2'd2, ST_HOLDOFF=2'd3;
  - TIME_W default;
  - the default walk time constant (25) shared with the pedestrian light block.
- Sub-module `button_debounce` contains the synchroniser, debounce counter and rising-edge detect. Interface: clk, rst, raw, press_pulse, level. Parameter: DEBOUNCE_CYCLES.

Test Plan:
- Reset mid-WALK: assert `rst` with `time_left`=10 → same-cycle `ped_signal`=0, `time_left`=0, no `ped_done`; IDLE after release.
- Debounce:
  - `button` high 3 cycles (D=4) → no `ped_pending`.
  - `button` high 10 cycles → `ped_pending`=1 after edge 7, exactly one event.
- Full cycle: press, then `phase_done` pulse with `load_time`=25.
  - → `ped_signal`=1, `time_left`=25.
  - After 25 `sec_tick`s → `ped_signal`=0, `ped_done` one cycle, HOLDOFF.
  - After 5 more ticks → IDLE.
- Queued request: press during WALK (`load_time`=3) → after walk and 5 hold-off ticks, `ped_pending`=1 without a new press.
- Zero load: `load_time`=0 at `phase_done` → `ped_signal` stays 0, `ped_done` pulses, HOLDOFF entered.
- Simultaneity:
  - Press event and `phase_done` same cycle in IDLE → PENDING only, `ped_signal`=0.
  - Final tick plus press in WALK → `queued`=1.
